// File: rtl/cache_mem_arb.sv
// Arbitrates Icache line refills and Dcache refills/writebacks onto a single
// burst memory port. One requester owns the port for a full BEATS-word burst.
// Simultaneous requests alternate between the caches, and the Icache wins the
// first tie after reset.
module cache_mem_arb #(
    parameter int BEATS = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ic_req_i,
    input  logic [31:0] ic_addr_i,
    output logic [31:0] ic_rdata_o,
    output logic        ic_rvalid_o,
    output logic        ic_done_o,

    input  logic        dc_req_i,
    input  logic        dc_we_i,
    input  logic [31:0] dc_addr_i,
    input  logic [31:0] dc_wdata_i,
    output logic        dc_wnext_o,
    output logic [31:0] dc_rdata_o,
    output logic        dc_rvalid_o,
    output logic        dc_done_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,

    output logic        busy_o
);

    localparam int CW = $clog2(BEATS);
    localparam int BW = 30 - CW;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

    state_t        state;
    logic          last_d;      // 1 when the most recent grant went to the Dcache
    logic          we;          // captured Dcache request type for the current burst
    logic [CW-1:0] cnt;
    logic [BW-1:0] base;
    logic          mem_req_q;
    logic          mem_we_q;
    logic          ic_done_q;
    logic          dc_done_q;
    logic          beat_ack;
    logic          last_beat;

    // The word-offset bits of the line addresses are not used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ic_addr_i[CW+1:0], dc_addr_i[CW+1:0]};

    // An acknowledge only counts while a beat is actually being requested.
    assign beat_ack  = mem_ack_i & mem_req_q;
    assign last_beat = (cnt == CW'(BEATS - 1));

    // Arbitration, burst sequencing and registered port/done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            we        <= 1'b0;
            cnt       <= '0;
            base      <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
        end else begin
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ic_req_i && (!dc_req_i || last_d)) begin
                        state     <= GNT_I;
                        last_d    <= 1'b0;
                        base      <= ic_addr_i[31:CW+2];
                        we        <= 1'b0;
                        cnt       <= '0;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                    end else if (dc_req_i) begin
                        state     <= GNT_D;
                        last_d    <= 1'b1;
                        base      <= dc_addr_i[31:CW+2];
                        we        <= dc_we_i;
                        cnt       <= '0;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= dc_we_i;
                    end
                end
                GNT_I, GNT_D: begin
                    if (beat_ack) begin
                        // cnt wraps back to zero after the final beat
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            state     <= DONE;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            ic_done_q <= (state == GNT_I);
                            dc_done_q <= (state == GNT_D);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = {base, cnt, 2'b00};
    assign mem_wdata_o = (state == GNT_D && we) ? dc_wdata_i : 32'h0;

    assign ic_rdata_o  = mem_rdata_i;
    assign ic_rvalid_o = beat_ack & (state == GNT_I);
    assign dc_rdata_o  = mem_rdata_i;
    assign dc_rvalid_o = beat_ack & (state == GNT_D) & ~we;
    assign dc_wnext_o  = beat_ack & (state == GNT_D) & we;

    assign ic_done_o   = ic_done_q;
    assign dc_done_o   = dc_done_q;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_cache_mem_arb.sv
// Randomized bench for cache_mem_arb. It keeps a transaction-level model:
// it predicts the owner of each burst from the pending requests and the owner
// of the previous grant, then derives the beat addresses, write data and
// expected pass-through outputs for every beat from the line address.
module tb_cache_mem_arb;

    localparam int BEATS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req_i;
    logic [31:0] ic_addr_i;
    logic [31:0] ic_rdata_o;
    logic        ic_rvalid_o;
    logic        ic_done_o;
    logic        dc_req_i;
    logic        dc_we_i;
    logic [31:0] dc_addr_i;
    logic [31:0] dc_wdata_i;
    logic        dc_wnext_o;
    logic [31:0] dc_rdata_o;
    logic        dc_rvalid_o;
    logic        dc_done_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        busy_o;

    int errs   = 0;
    int checks = 0;
    bit m_last_d;   // model: previous grant went to the Dcache

    cache_mem_arb #(.BEATS(BEATS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ic_req_i    (ic_req_i),
        .ic_addr_i   (ic_addr_i),
        .ic_rdata_o  (ic_rdata_o),
        .ic_rvalid_o (ic_rvalid_o),
        .ic_done_o   (ic_done_o),
        .dc_req_i    (dc_req_i),
        .dc_we_i     (dc_we_i),
        .dc_addr_i   (dc_addr_i),
        .dc_wdata_i  (dc_wdata_i),
        .dc_wnext_o  (dc_wnext_o),
        .dc_rdata_o  (dc_rdata_o),
        .dc_rvalid_o (dc_rvalid_o),
        .dc_done_o   (dc_done_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        chk(tag, {31'b0, got}, {31'b0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stray acknowledges with nothing granted must produce nothing.
    task automatic idle_ack();
        ic_req_i  = 1'b0;
        dc_req_i  = 1'b0;
        mem_ack_i = 1'b1;
        @(negedge clk);
        chk("idle_ack_quiet", {27'b0, ic_rvalid_o, dc_rvalid_o, dc_wnext_o, ic_done_o, dc_done_o}, 32'h0);
        chk1("idle_ack_req", mem_req_o, 1'b0);
        step();
        mem_ack_i = 1'b0;
        @(negedge clk);
        chk1("idle_ack_busy", busy_o, 1'b0);
        chk1("idle_ack_req2", mem_req_o, 1'b0);
        step();
    endtask

    // Issue the requested bursts and check every cycle until all complete.
    // ack_mode: 0 = ack every cycle, 1 = ack every other cycle, 2 = random.
    task automatic run(input bit want_i, input bit want_d, input bit dwe,
                       input logic [31:0] ia, input logic [31:0] da,
                       input int ack_mode, input bit drop_i, input logic [31:0] wbase);
        bit          pend_i;
        bit          pend_d;
        bit          own_d;
        bit          wev;
        logic [31:0] base;
        logic [31:0] rd;
        logic [31:0] wd;
        int          beat;
        int          wcnt;
        pend_i    = want_i;
        pend_d    = want_d;
        ic_addr_i = ia;
        dc_addr_i = da;
        dc_we_i   = dwe;
        ic_req_i  = want_i;
        dc_req_i  = want_d;
        mem_ack_i = 1'b0;
        while (pend_i || pend_d) begin
            if (pend_i && pend_d) own_d = ~m_last_d;
            else                  own_d = pend_d;
            m_last_d = own_d;
            wev  = own_d & dwe;
            base = (own_d ? da : ia) & ~32'(BEATS * 4 - 1);
            @(negedge clk);
            chk1("arb_busy", busy_o, 1'b0);
            chk1("arb_req", mem_req_o, 1'b0);
            step();
            beat = 0;
            wcnt = 0;
            while (beat < BEATS && wcnt < 60) begin
                case (ack_mode)
                    0:       mem_ack_i = 1'b1;
                    1:       mem_ack_i = wcnt[0];
                    default: mem_ack_i = ($urandom_range(0, 3) != 0);
                endcase
                rd          = $urandom;
                mem_rdata_i = rd;
                wd          = wbase + 32'(beat);
                dc_wdata_i  = wd;
                if (drop_i && !own_d && beat == 1) ic_req_i = 1'b0;
                // The owner's address and type wander during the burst.
                if (own_d) begin
                    dc_addr_i = $urandom;
                    dc_we_i   = 1'($urandom_range(0, 1));
                end else begin
                    ic_addr_i = $urandom;
                end
                @(negedge clk);
                chk1("beat_req", mem_req_o, 1'b1);
                chk1("beat_busy", busy_o, 1'b1);
                chk("beat_addr", mem_addr_o, base + 32'(beat * 4));
                chk1("beat_we", mem_we_o, wev);
                chk("beat_wdata", mem_wdata_o, wev ? wd : 32'h0);
                chk1("ic_rvalid", ic_rvalid_o, mem_ack_i & ~own_d);
                chk1("dc_rvalid", dc_rvalid_o, mem_ack_i & own_d & ~wev);
                chk1("dc_wnext", dc_wnext_o, mem_ack_i & wev);
                chk("beat_done", {30'b0, ic_done_o, dc_done_o}, 32'h0);
                if (mem_ack_i) begin
                    if (own_d) chk("dc_rdata", dc_rdata_o, rd);
                    else       chk("ic_rdata", ic_rdata_o, rd);
                    beat++;
                end
                wcnt++;
                step();
            end
            if (beat < BEATS) chk("burst_timeout", 32'(beat), 32'(BEATS));
            mem_ack_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk1("done_ic", ic_done_o, ~own_d);
            chk1("done_dc", dc_done_o, own_d);
            chk1("done_req", mem_req_o, 1'b0);
            chk1("done_busy", busy_o, 1'b1);
            chk("done_quiet", {29'b0, ic_rvalid_o, dc_rvalid_o, dc_wnext_o}, 32'h0);
            step();
            mem_ack_i = 1'b0;
            if (own_d) begin
                dc_req_i = 1'b0;
                pend_d   = 1'b0;
            end else begin
                ic_req_i = 1'b0;
                pend_i   = 1'b0;
            end
        end
    endtask

    // Reset asserted in the middle of beat 2 of a Dcache refill.
    task automatic reset_mid_burst();
        ic_req_i  = 1'b0;
        dc_req_i  = 1'b1;
        dc_we_i   = 1'b0;
        dc_addr_i = 32'h0000_4400;
        step();
        mem_ack_i = 1'b1;
        step();
        step();
        @(negedge clk);
        chk1("pre_rst_req", mem_req_o, 1'b1);
        chk("pre_rst_addr", mem_addr_o, 32'h0000_4408);
        #1 rst_n = 1'b0;
        #1;
        chk1("rst_req", mem_req_o, 1'b0);
        chk1("rst_we", mem_we_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk1("rst_busy", busy_o, 1'b0);
        chk("rst_quiet", {27'b0, ic_rvalid_o, dc_rvalid_o, dc_wnext_o, ic_done_o, dc_done_o}, 32'h0);
        dc_req_i  = 1'b0;
        mem_ack_i = 1'b0;
        step();
        rst_n    = 1'b1;
        m_last_d = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        ic_req_i    = 1'b0;
        ic_addr_i   = 32'h0;
        dc_req_i    = 1'b0;
        dc_we_i     = 1'b0;
        dc_addr_i   = 32'h0;
        dc_wdata_i  = 32'h0;
        mem_rdata_i = 32'h0;
        mem_ack_i   = 1'b1;
        m_last_d    = 1'b1;
        repeat (3) step();
        chk1("reset_req", mem_req_o, 1'b0);
        chk1("reset_we", mem_we_o, 1'b0);
        chk("reset_addr", mem_addr_o, 32'h0);
        chk1("reset_busy", busy_o, 1'b0);
        chk("reset_quiet", {27'b0, ic_rvalid_o, dc_rvalid_o, dc_wnext_o, ic_done_o, dc_done_o}, 32'h0);
        mem_ack_i = 1'b0;
        rst_n     = 1'b1;
        step();

        idle_ack();
        // Ties right after reset: Icache then Dcache, twice.
        run(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3010, 0, 1'b0, 32'h0);
        run(1'b1, 1'b1, 1'b1, 32'h0000_2100, 32'h0000_3110, 2, 1'b0, 32'hA500);
        // Icache alone, back-to-back acks.
        run(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 0, 1'b0, 32'h0);
        // Tie after an Icache grant goes to the Dcache.
        run(1'b1, 1'b1, 1'b0, 32'h0000_5000, 32'h0000_6000, 2, 1'b0, 32'h0);
        // Dcache writeback, ack every other cycle, data = beat index.
        run(1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_0040, 1, 1'b0, 32'h0);
        // Icache request dropped after beat 1.
        run(1'b1, 1'b0, 1'b0, 32'h0000_7780, 32'h0, 2, 1'b1, 32'h0);
        // Dcache refill with random acks.
        run(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFF0, 2, 1'b0, 32'h0);

        for (int i = 0; i < 24; i++) begin
            bit wi;
            bit wdd;
            wi  = 1'($urandom_range(0, 1));
            wdd = 1'($urandom_range(0, 1));
            if (!wi && !wdd) wi = 1'b1;
            run(wi, wdd, 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) idle_ack();
        end

        reset_mid_burst();
        run(1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, 2, 1'b0, 32'h55);
        idle_ack();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arb.md
CACHE_MEM_ARB -- requirements
Module: cache_mem_arb

Interface
REQ-001 Parameter BEATS, default 4, words per cache line; power of two, at least 2; CW = log2(BEATS).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ic_req_i  input  1  Icache line-refill (read) request; held high until ic_done_o.
REQ-005 ic_addr_i  input  32  Icache line address; bits [CW+1:0] ignored.
REQ-006 ic_rdata_o / ic_rvalid_o  output  32 / 1  Icache read beat data / beat valid.
REQ-007 ic_done_o  output  1  one-cycle pulse: Icache burst complete.
REQ-008 dc_req_i  input  1  Dcache request; held high until dc_done_o.
REQ-009 dc_we_i  input  1  Dcache request type: 1 = writeback, 0 = refill.
REQ-010 dc_addr_i  input  32  Dcache line address; bits [CW+1:0] ignored.
REQ-011 dc_wdata_i  input  32  writeback data for the current beat.
REQ-012 dc_wnext_o  output  1  write beat accepted; requester advances dc_wdata_i at this edge.
REQ-013 dc_rdata_o / dc_rvalid_o / dc_done_o  output  32 / 1 / 1  Dcache read data / beat valid / done pulse.
REQ-014 mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o  output  1 / 1 / 32 / 32  single memory port request.
REQ-015 mem_rdata_i / mem_ack_i  input  32 / 1  memory read data / beat acknowledge.
REQ-016 busy_o  output  1  high in any state other than IDLE.

Function
REQ-017 States: IDLE, GNT_I, GNT_D, DONE; one-hot or binary encoding is acceptable.
REQ-018 IDLE, ic_req_i only: next state GNT_I; dc_req_i only: next state GNT_D; neither: stay in IDLE.
REQ-019 IDLE, both requests: grant the requester not recorded in last_d (last_d = 1 -> Icache, last_d = 0 -> Dcache); last_d updates on every grant.
REQ-020 On grant: capture line base = addr[31:CW+2], capture dc_we_i for Dcache, clear beat counter cnt (CW bits); mem_req_o = 1 in the first cycle of the grant state.
REQ-021 mem_addr_o = {base, cnt, 2'b00}; mem_req_o, mem_we_o and mem_addr_o are registered and held stable until mem_ack_i.
REQ-022 mem_we_o is 1 only in GNT_D with the captured we = 1; it is always 0 in GNT_I.
REQ-023 mem_wdata_o = dc_wdata_i combinationally in GNT_D with we = 1; otherwise 0.
REQ-024 mem_ack_i is ignored while mem_req_o = 0.
REQ-025 On ack with cnt < BEATS-1: cnt increments; the next beat address appears the following cycle with mem_req_o still high, giving back-to-back beats.
REQ-026 On ack with cnt = BEATS-1: mem_req_o drops and the next state is DONE; cnt wraps to 0.
REQ-027 ic_rvalid_o = mem_ack_i & GNT_I and ic_rdata_o = mem_rdata_i, both combinational.
REQ-028 dc_rvalid_o = mem_ack_i & GNT_D & !we and dc_rdata_o = mem_rdata_i, both combinational.
REQ-029 dc_wnext_o = mem_ack_i & GNT_D & we, combinational.
REQ-030 DONE lasts exactly one cycle: the owner's done_o = 1, requests are not sampled, and the next state is IDLE.
REQ-031 The requester deasserts req at the edge following its done_o pulse.
REQ-032 Minimum gap between the final ack of one burst and mem_req_o of the next burst is 2 cycles (DONE, IDLE).
REQ-033 Request deassertion or change of addr/we during a grant is ignored; the burst always completes all BEATS beats.

Reset
REQ-034 rst_n low, including mid-burst: state = IDLE, cnt = 0, last_d = 1.
REQ-035 rst_n low: mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, both done_o = 0, busy_o = 0.
REQ-036 rst_n low: all combinational valid and wnext outputs = 0.
REQ-037 After rst_n deasserts, the first tie is granted to the Icache.

Verification
REQ-038 Icache alone, addr 0x0000_1234, memory acks every cycle -> mem_addr_o 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; 4 ic_rvalid_o pulses; ic_done_o one cycle after the last ack.
REQ-039 Both requests in the same cycle after reset -> Icache served first, then Dcache; on the next tie the Icache is served first again only if the Dcache was served last.
REQ-040 Dcache writeback, addr 0x8000_0040, ack every other cycle, dc_wdata_i = beat index -> mem_wdata_o 0, 1, 2, 3 with mem_we_o = 1; exactly 4 dc_wnext_o pulses; mem_addr_o stable across each wait cycle.
REQ-041 ic_req_i dropped after beat 1 -> remaining beats still issued; ic_done_o still pulses.
REQ-042 rst_n asserted during beat 2 of a Dcache refill -> mem_req_o = 0 immediately (asynchronous); a tie after release is granted to the Icache.
REQ-043 mem_ack_i pulsed while IDLE -> no valid, wnext or done outputs and no state change.
